mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Shares the single core memory port between fetch (imem, read-only) and execute-stage LSU (dmem).
// - Queues one pending request per requester, grants one transaction at a time, and returns each
//   response only to its owner.
// - Sits between fetch/execute stages and the bus/memory interface. One clock domain.
// PARAMETERS
// - XLEN  32  data and address width
// PORTS
// - clk          in   1       clock, rising edge
// - rst          in   1       reset, asynchronous, active-low
// - imem_valid   in   1       fetch request pulse (1 cycle)
// - imem_addr    in   XLEN    fetch address
// - imem_rdata   out  XLEN    fetch read data, valid when imem_ready=1
// - imem_ready   out  1       fetch response strobe (1 cycle)
// - dmem_valid   in   1       LSU request pulse (1 cycle)
// - dmem_addr    in   XLEN    LSU address
// - dmem_wdata   in   XLEN    LSU store data
// - dmem_wstrb   in   XLEN/8  LSU byte strobes; 0 = load
// - dmem_rdata   out  XLEN    LSU read data, valid when dmem_ready=1
// - dmem_ready   out  1       LSU response strobe (1 cycle)
// - mem_valid    out  1       memory request pulse (1 cycle, registered)
// - mem_instr    out  1       1 = instruction fetch
// - mem_addr     out  XLEN    memory address, held until mem_ready
// - mem_wdata    out  XLEN    store data, held until mem_ready
// - mem_wstrb    out  XLEN/8  byte strobes, held until mem_ready
// - mem_rdata    in   XLEN    memory read data
// - mem_ready    in   1       memory completion strobe
// BEHAVIOUR
// - Reset (rst=0, async): state=IDLE; pending/discard flags cleared; last-grant=IMEM.
//   All mem_* outputs and *_ready are 0. *_rdata are 0.
// - Capture: a valid pulse latches addr/wdata/wstrb into that requester's pending slot.
//   A later pulse from the same requester overwrites the slot.
// - States:
//   - IDLE: at a clock edge, if a request is pending or pulsing this cycle, grant it, load the
//     mem_* registers, and go to IBUSY or DBUSY. mem_valid=1 for exactly the next cycle.
//   - IBUSY/DBUSY: wait for mem_ready; mem_ready is sampled from the mem_valid cycle onward.
//     On mem_ready: go to IDLE; mem_valid=0; the owner's pending slot is cleared.
// - Priority: dmem wins when both are pending.
// - Latency: pulse at cycle N with the arbiter idle -> mem_valid at N+1.
//   Response: owner_ready=mem_ready in the same cycle (combinational), with
//   owner_rdata=mem_rdata in that cycle, otherwise 0.
// - Back-to-back: after completion, one IDLE cycle, then the next grant (mem_valid 2 cycles
//   after mem_ready).
// - Redirect: an owner pulse during its own in-flight transaction sets discard. At completion,
//   ready/rdata are suppressed and the new request stays pending. The transaction itself is
//   never cancelled.
// - Non-owner pulse during a transaction: latched pending, served after completion.
// - mem_ready in IDLE is ignored, e.g. a stale response after a mid-transaction reset.
// - Simultaneous imem and dmem pulses in IDLE: grant dmem; imem stays pending.
// CONFIGURATION
// - ARB_FAIRNESS_EN defined: when both are pending, grant the requester not granted last
//   (round-robin, last-grant register). After reset dmem wins the first tie.
// - ARB_FAIRNESS_EN undefined: fixed dmem priority. The last-grant register is absent.
// TESTING
// - Reset mid-DBUSY with mem_ready=1 one cycle after release -> no *_ready, mem_valid stays 0.
// - imem pulse addr=0x100; mem_ready 3 cycles after mem_valid, mem_rdata=0x00000013
//   -> mem_instr=1, imem_ready=1, imem_rdata=0x13.
// - imem and dmem pulse same cycle (dmem addr=0x2000, wstrb=0xF, wdata=0xDEADBEEF)
//   -> dmem is granted first; imem granted 2 cycles after dmem mem_ready.
// - imem addr=0x100 in flight, new imem pulse addr=0x200 -> first response suppressed;
//   0x200 issued and returned.
// - dmem pulse every completion for 10 transactions plus a standing imem request
//   -> fixed mode: imem starves; ARB_FAIRNESS_EN: alternates dmem/imem.
// - dmem load addr=0x3004, wstrb=0 with mem_ready in the mem_valid cycle
//   -> dmem_ready asserted in cycle N+1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one memory port between fetch (imem) and LSU (dmem); optional round-robin via ARB_FAIRNESS_EN.
// Latency: request pulse in idle -> mem_valid next cycle; response strobe is combinational from mem_ready.
// Backpressure: one pending slot per requester, re-pulses overwrite it; the memory holds off via mem_ready.
module mem_arbiter #(
    parameter int XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_valid,
    input  logic [XLEN-1:0]   imem_addr,
    output logic [XLEN-1:0]   imem_rdata,
    output logic              imem_ready,
    input  logic              dmem_valid,
    input  logic [XLEN-1:0]   dmem_addr,
    input  logic [XLEN-1:0]   dmem_wdata,
    input  logic [XLEN/8-1:0] dmem_wstrb,
    output logic [XLEN-1:0]   dmem_rdata,
    output logic              dmem_ready,
    output logic              mem_valid,
    output logic              mem_instr,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {IDLE, IBUSY, DBUSY} state_t;

    state_t            state_q, state_d;
    logic              i_pend_q, i_pend_d, d_pend_q, d_pend_d;
    logic              i_disc_q, i_disc_d, d_disc_q, d_disc_d;
    logic [XLEN-1:0]   i_addr_q, i_addr_d, d_addr_q, d_addr_d;
    logic [XLEN-1:0]   d_wdata_q, d_wdata_d;
    logic [XLEN/8-1:0] d_wstrb_q, d_wstrb_d;
    logic              mem_valid_q, mem_valid_d, mem_instr_q, mem_instr_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [XLEN/8-1:0] mem_wstrb_q, mem_wstrb_d;
`ifdef ARB_FAIRNESS_EN
    logic              last_d_q, last_d_d;   // 1 = dmem was granted last
`endif

    logic i_req, d_req, grant_i, grant_d, i_done, d_done;

    always_comb begin
        i_req  = i_pend_q | imem_valid;
        d_req  = d_pend_q | dmem_valid;
`ifdef ARB_FAIRNESS_EN
        grant_d = d_req & (~i_req | ~last_d_q);
`else
        grant_d = d_req;
`endif
        grant_i = i_req & ~grant_d;
        i_done  = (state_q == IBUSY) & mem_ready;
        d_done  = (state_q == DBUSY) & mem_ready;

        state_d     = state_q;
        i_pend_d    = i_pend_q;
        d_pend_d    = d_pend_q;
        i_disc_d    = i_disc_q;
        d_disc_d    = d_disc_q;
        i_addr_d    = i_addr_q;
        d_addr_d    = d_addr_q;
        d_wdata_d   = d_wdata_q;
        d_wstrb_d   = d_wstrb_q;
        mem_valid_d = 1'b0;
        mem_instr_d = mem_instr_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
`ifdef ARB_FAIRNESS_EN
        last_d_d    = last_d_q;
`endif

        if (imem_valid) begin
            i_pend_d = 1'b1;
            i_addr_d = imem_addr;
        end
        if (dmem_valid) begin
            d_pend_d  = 1'b1;
            d_addr_d  = dmem_addr;
            d_wdata_d = dmem_wdata;
            d_wstrb_d = dmem_wstrb;
        end

        // A re-pulse from the current owner redirects it: its in-flight response is dropped.
        if ((state_q == IBUSY) && imem_valid) i_disc_d = 1'b1;
        if (i_done)                           i_disc_d = 1'b0;
        if ((state_q == DBUSY) && dmem_valid) d_disc_d = 1'b1;
        if (d_done)                           d_disc_d = 1'b0;

        case (state_q)
            IDLE: begin
                // Slot _d values already include this cycle's pulse, so a fresh request issues directly.
                if (grant_d) begin
                    state_d     = DBUSY;
                    mem_valid_d = 1'b1;
                    mem_instr_d = 1'b0;
                    mem_addr_d  = d_addr_d;
                    mem_wdata_d = d_wdata_d;
                    mem_wstrb_d = d_wstrb_d;
                    d_pend_d    = 1'b0;
`ifdef ARB_FAIRNESS_EN
                    last_d_d    = 1'b1;
`endif
                end else if (grant_i) begin
                    state_d     = IBUSY;
                    mem_valid_d = 1'b1;
                    mem_instr_d = 1'b1;
                    mem_addr_d  = i_addr_d;
                    mem_wdata_d = '0;
                    mem_wstrb_d = '0;
                    i_pend_d    = 1'b0;
`ifdef ARB_FAIRNESS_EN
                    last_d_d    = 1'b0;
`endif
                end
            end
            IBUSY:   if (mem_ready) state_d = IDLE;
            DBUSY:   if (mem_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            i_pend_q    <= 1'b0;
            d_pend_q    <= 1'b0;
            i_disc_q    <= 1'b0;
            d_disc_q    <= 1'b0;
            i_addr_q    <= '0;
            d_addr_q    <= '0;
            d_wdata_q   <= '0;
            d_wstrb_q   <= '0;
            mem_valid_q <= 1'b0;
            mem_instr_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
`ifdef ARB_FAIRNESS_EN
            last_d_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            i_pend_q    <= i_pend_d;
            d_pend_q    <= d_pend_d;
            i_disc_q    <= i_disc_d;
            d_disc_q    <= d_disc_d;
            i_addr_q    <= i_addr_d;
            d_addr_q    <= d_addr_d;
            d_wdata_q   <= d_wdata_d;
            d_wstrb_q   <= d_wstrb_d;
            mem_valid_q <= mem_valid_d;
            mem_instr_q <= mem_instr_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
`ifdef ARB_FAIRNESS_EN
            last_d_q    <= last_d_d;
`endif
        end
    end

    assign mem_valid  = mem_valid_q;
    assign mem_instr  = mem_instr_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign imem_ready = i_done & ~(i_disc_q | imem_valid);
    assign dmem_ready = d_done & ~(d_disc_q | dmem_valid);
    assign imem_rdata = imem_ready ? mem_rdata : '0;
    assign dmem_rdata = dmem_ready ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_valid, dmem_valid, mem_ready;
    logic [31:0] imem_addr, dmem_addr, dmem_wdata, mem_rdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] imem_rdata, dmem_rdata, mem_addr, mem_wdata;
    logic        imem_ready, dmem_ready, mem_valid, mem_instr;
    logic [3:0]  mem_wstrb;

    int n_checks = 0;
    int n_errors = 0;

`ifdef ARB_FAIRNESS_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    mem_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .imem_valid(imem_valid), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .dmem_valid(dmem_valid), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb),
        .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0;
        imem_valid = 1'b0; imem_addr = '0;
        dmem_valid = 1'b0; dmem_addr = '0; dmem_wdata = '0; dmem_wstrb = '0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;   // stray response while held in reset
        repeat (2) @(posedge clk);
        smp();
        check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
        check("rst_mem_instr", {31'd0, mem_instr}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("rst_readies", {30'd0, imem_ready, dmem_ready}, 32'd0);
        check("rst_imem_rdata", imem_rdata, 32'd0);
        check("rst_dmem_rdata", dmem_rdata, 32'd0);
        cyc(); rst = 1'b1; mem_ready = 1'b0; mem_rdata = '0;

        // Fetch with a 3-cycle memory wait
        cyc(); imem_valid = 1'b1; imem_addr = 32'h100;
        smp(); check("a_no_early_valid", {31'd0, mem_valid}, 32'd0);
        cyc(); imem_valid = 1'b0;
        smp(); check("a_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("a_mem_instr", {31'd0, mem_instr}, 32'd1);
        check("a_mem_addr", mem_addr, 32'h100);
        cyc();
        smp(); check("a_valid_pulse", {31'd0, mem_valid}, 32'd0);
        check("a_no_ready_yet", {31'd0, imem_ready}, 32'd0);
        check("a_addr_held", mem_addr, 32'h100);
        cyc();
        cyc(); mem_ready = 1'b1; mem_rdata = 32'h0000_0013;
        smp(); check("a_imem_ready", {31'd0, imem_ready}, 32'd1);
        check("a_imem_rdata", imem_rdata, 32'h13);
        check("a_dmem_ready", {31'd0, dmem_ready}, 32'd0);
        cyc(); mem_ready = 1'b0;
        smp(); check("a_ready_drop", {31'd0, imem_ready}, 32'd0);
        check("a_rdata_zero", imem_rdata, 32'd0);

        // Simultaneous pulses: dmem store first, fetch two cycles after its completion
        cyc(); imem_valid = 1'b1; imem_addr = 32'h400;
        dmem_valid = 1'b1; dmem_addr = 32'h2000; dmem_wdata = 32'hDEAD_BEEF; dmem_wstrb = 4'hF;
        cyc(); imem_valid = 1'b0; dmem_valid = 1'b0;
        smp(); check("b_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("b_mem_instr", {31'd0, mem_instr}, 32'd0);
        check("b_mem_addr", mem_addr, 32'h2000);
        check("b_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("b_mem_wstrb", {28'd0, mem_wstrb}, 32'hF);
        cyc(); mem_ready = 1'b1; mem_rdata = 32'h77;
        smp(); check("b_dmem_ready", {31'd0, dmem_ready}, 32'd1);
        check("b_dmem_rdata", dmem_rdata, 32'h77);
        check("b_imem_quiet", {31'd0, imem_ready}, 32'd0);
        cyc(); mem_ready = 1'b0;
        smp(); check("b_idle_gap", {31'd0, mem_valid}, 32'd0);
        cyc();
        smp(); check("b_i_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("b_i_mem_instr", {31'd0, mem_instr}, 32'd1);
        check("b_i_mem_addr", mem_addr, 32'h400);
        check("b_i_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        cyc(); mem_ready = 1'b1; mem_rdata = 32'h99;
        smp(); check("b_imem_ready", {30'd0, imem_ready, dmem_ready}, 32'd2);
        check("b_imem_rdata", imem_rdata, 32'h99);
        cyc(); mem_ready = 1'b0;

        // Fetch redirect while in flight
        cyc(); imem_valid = 1'b1; imem_addr = 32'h100;
        cyc(); imem_valid = 1'b0;
        smp(); check("c_mem_addr0", mem_addr, 32'h100);
        cyc(); imem_valid = 1'b1; imem_addr = 32'h200;
        cyc(); imem_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'hAAAA;
        smp(); check("c_suppressed", {31'd0, imem_ready}, 32'd0);
        check("c_rdata_zero", imem_rdata, 32'd0);
        cyc(); mem_ready = 1'b0;
        smp(); check("c_idle", {31'd0, mem_valid}, 32'd0);
        cyc();
        smp(); check("c_reissue", {31'd0, mem_valid}, 32'd1);
        check("c_mem_addr1", mem_addr, 32'h200);
        cyc(); mem_ready = 1'b1; mem_rdata = 32'hBBBB;
        smp(); check("c_imem_ready", {31'd0, imem_ready}, 32'd1);
        check("c_imem_rdata", imem_rdata, 32'hBBBB);
        cyc(); mem_ready = 1'b0;

        // Load completing in the mem_valid cycle
        cyc(); dmem_valid = 1'b1; dmem_addr = 32'h3004; dmem_wdata = '0; dmem_wstrb = 4'h0;
        cyc(); dmem_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h55;
        smp(); check("d_mem_valid", {31'd0, mem_valid}, 32'd1);
        check("d_mem_addr", mem_addr, 32'h3004);
        check("d_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        check("d_dmem_ready", {31'd0, dmem_ready}, 32'd1);
        check("d_dmem_rdata", dmem_rdata, 32'h55);
        cyc(); mem_ready = 1'b0;
        smp(); check("d_ready_drop", {31'd0, dmem_ready}, 32'd0);
        check("d_no_valid", {31'd0, mem_valid}, 32'd0);

        // Reset in the middle of a store, stale mem_ready afterwards
        cyc(); dmem_valid = 1'b1; dmem_addr = 32'h4000; dmem_wdata = 32'h1; dmem_wstrb = 4'hF;
        cyc(); dmem_valid = 1'b0;
        smp(); check("e_mem_valid", {31'd0, mem_valid}, 32'd1);
        cyc(); rst = 1'b0;
        smp(); check("e_rst_valid", {31'd0, mem_valid}, 32'd0);
        check("e_rst_addr", mem_addr, 32'd0);
        cyc(); rst = 1'b1;
        cyc(); mem_ready = 1'b1; mem_rdata = 32'h1234;
        smp(); check("e_stale_ready", {30'd0, imem_ready, dmem_ready}, 32'd0);
        check("e_stale_rdata", dmem_rdata, 32'd0);
        cyc(); mem_ready = 1'b0;
        smp(); check("e_no_valid0", {31'd0, mem_valid}, 32'd0);
        cyc();
        smp(); check("e_no_valid1", {31'd0, mem_valid}, 32'd0);

        // Repeated dmem traffic against a standing fetch request
        cyc();
        for (int t = 0; t < 10; t++) begin
            logic exp_i;
            exp_i = FAIR ? logic'(t % 2) : 1'b0;
            mem_ready = 1'b0;
            dmem_valid = 1'b1; dmem_addr = 32'h5000 + 32'(t * 4); dmem_wstrb = 4'h0;
            imem_valid = (t == 0) || (FAIR && (t % 2 == 0));
            imem_addr = 32'h600;
            cyc(); dmem_valid = 1'b0; imem_valid = 1'b0;
            smp(); check($sformatf("f_valid%0d", t), {31'd0, mem_valid}, 32'd1);
            check($sformatf("f_instr%0d", t), {31'd0, mem_instr}, {31'd0, exp_i});
            cyc(); mem_ready = 1'b1; mem_rdata = 32'(t);
            smp(); check($sformatf("f_ready%0d", t), {30'd0, imem_ready, dmem_ready},
                         exp_i ? 32'd2 : 32'd1);
            cyc();
        end
        mem_ready = 1'b0;
        repeat (4) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
